tensor_feed_sequencer: RTL and testbench

- Upstream feeder for systolic_array_sv inside the tensor system.
- Pops one row-vector per cycle from the SIZE A-lane and SIZE B-lane input FIFOs (ast_fifo_v, show-ahead).
- Skews lane i by i cycles to form the diagonal wavefront, drives a_in/b_in, and sequences load_en/mult_en/acc_en for one K-long accumulation pass.

---
 rtl/tensor_feed_sequencer.sv | 158 +++++++++++++++
 tb/tb_tensor_feed_sequencer.sv | 297 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/tensor_feed_sequencer.sv
// Operand feeder for the systolic array: pops lane FIFOs, skews lane i by i cycles, sequences load/mult/acc.
// Optional stall counter output is enabled by defining TENSOR_FEED_PERF_EN.
module tensor_feed_sequencer #(
    parameter int unsigned DATAWIDTH = 14,
    parameter int unsigned SIZE      = 8,
    parameter int unsigned KLEN_W    = 10
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic                      start,
    input  logic [KLEN_W-1:0]         k_len,
    input  logic [SIZE*DATAWIDTH-1:0] a_fifo_q,
    input  logic [SIZE-1:0]           a_fifo_empty,
    input  logic [SIZE*DATAWIDTH-1:0] b_fifo_q,
    input  logic [SIZE-1:0]           b_fifo_empty,
    output logic [SIZE-1:0]           a_fifo_rdreq,
    output logic [SIZE-1:0]           b_fifo_rdreq,
    output logic [SIZE*DATAWIDTH-1:0] a_in,
    output logic [SIZE*DATAWIDTH-1:0] b_in,
    output logic                      load_en,
    output logic                      mult_en,
    output logic                      acc_en,
    output logic                      busy,
    output logic                      done
`ifdef TENSOR_FEED_PERF_EN
    ,
    output logic [15:0]               stall_cycles
`endif
);

    localparam int unsigned FCNT_W = $clog2(SIZE + 1);

    localparam logic [2:0] S_IDLE   = 3'd0;
    localparam logic [2:0] S_CLEAR  = 3'd1;
    localparam logic [2:0] S_STREAM = 3'd2;
    localparam logic [2:0] S_FLUSH  = 3'd3;
    localparam logic [2:0] S_DONE   = 3'd4;

    logic [2:0]        state, state_nxt;
    logic [KLEN_W-1:0] kcnt, kcnt_nxt;
    logic [FCNT_W-1:0] fcnt, fcnt_nxt;
    logic              pop, stall, shift;
    logic [SIZE-1:0]   out_valid;

    // A pop needs every A and B lane to have data so the wavefront stays aligned
    assign pop   = (state == S_STREAM) && !(|a_fifo_empty) && !(|b_fifo_empty);
    assign stall = (state == S_STREAM) && !pop;
    assign shift = !stall;

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= S_IDLE;
            kcnt  <= '0;
            fcnt  <= '0;
        end else begin
            state <= state_nxt;
            kcnt  <= kcnt_nxt;
            fcnt  <= fcnt_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        kcnt_nxt  = kcnt;
        fcnt_nxt  = fcnt;
        case (state)
            S_IDLE: begin
                if (start) begin
                    state_nxt = S_CLEAR;
                    kcnt_nxt  = k_len;
                end
            end
            S_CLEAR: begin
                fcnt_nxt  = '0;
                state_nxt = (kcnt != '0) ? S_STREAM : S_DONE;
            end
            S_STREAM: begin
                if (pop) begin
                    kcnt_nxt = kcnt - KLEN_W'(1);
                    if (kcnt == KLEN_W'(1)) begin
                        state_nxt = S_FLUSH;
                        fcnt_nxt  = '0;
                    end
                end
            end
            S_FLUSH: begin
                fcnt_nxt = fcnt + FCNT_W'(1);
                if (fcnt == FCNT_W'(SIZE - 1)) begin
                    state_nxt = S_DONE;
                end
            end
            S_DONE:  state_nxt = S_IDLE;
            default: state_nxt = S_IDLE;
        endcase
    end

    assign load_en      = (state == S_CLEAR);
    assign busy         = (state == S_CLEAR) || (state == S_STREAM) || (state == S_FLUSH);
    assign done         = (state == S_DONE);
    assign a_fifo_rdreq = {SIZE{pop}};
    assign b_fifo_rdreq = {SIZE{pop}};
    assign mult_en      = !stall && (|out_valid);
    assign acc_en       = !stall && (|out_valid);

    // Lane i: shift chain of depth i+1; invalid slots carry zero data
    for (genvar i = 0; i < SIZE; i++) begin : g_lane
        logic [i:0][DATAWIDTH-1:0] a_sr, b_sr;
        logic [i:0]                v_sr;
        logic [DATAWIDTH-1:0]      a_new, b_new;

        assign a_new = pop ? a_fifo_q[i*DATAWIDTH +: DATAWIDTH] : '0;
        assign b_new = pop ? b_fifo_q[i*DATAWIDTH +: DATAWIDTH] : '0;

        if (i == 0) begin : g_d1
            always_ff @(posedge clk) begin
                if (reset) begin
                    a_sr <= '0;
                    b_sr <= '0;
                    v_sr <= '0;
                end else if (shift) begin
                    a_sr <= a_new;
                    b_sr <= b_new;
                    v_sr <= pop;
                end
            end
        end else begin : g_dn
            always_ff @(posedge clk) begin
                if (reset) begin
                    a_sr <= '0;
                    b_sr <= '0;
                    v_sr <= '0;
                end else if (shift) begin
                    a_sr <= {a_sr[i-1:0], a_new};
                    b_sr <= {b_sr[i-1:0], b_new};
                    v_sr <= {v_sr[i-1:0], pop};
                end
            end
        end

        assign a_in[i*DATAWIDTH +: DATAWIDTH] = a_sr[i];
        assign b_in[i*DATAWIDTH +: DATAWIDTH] = b_sr[i];
        assign out_valid[i]                   = v_sr[i];
    end

`ifdef TENSOR_FEED_PERF_EN
    // Saturating count of stalled STREAM cycles, restarted by each accepted start
    always_ff @(posedge clk) begin
        if (reset) begin
            stall_cycles <= '0;
        end else if ((state == S_IDLE) && start) begin
            stall_cycles <= '0;
        end else if (stall && (stall_cycles != 16'hFFFF)) begin
            stall_cycles <= stall_cycles + 16'd1;
        end
    end
`endif

endmodule

// File: tb/tb_tensor_feed_sequencer.sv
// Directed bench for tensor_feed_sequencer at SIZE=4: timing, stall, zero length, ignored start, reset, lane data.
module tb_tensor_feed_sequencer;

    localparam int unsigned DW = 14;
    localparam int unsigned SZ = 4;
    localparam int unsigned KW = 10;
    localparam int NC = 16;

    logic              clk = 1'b0;
    logic              reset, start, clr_pops;
    logic [KW-1:0]     k_len;
    logic [SZ*DW-1:0]  a_fifo_q, b_fifo_q, a_in, b_in;
    logic [SZ-1:0]     a_fifo_empty, b_fifo_empty, a_fifo_rdreq, b_fifo_rdreq;
    logic              load_en, mult_en, acc_en, busy, done;
`ifdef TENSOR_FEED_PERF_EN
    logic [15:0]       stall_cycles;
`endif

    int total = 0;
    int bad   = 0;
    int pop_a [SZ];
    int pop_b [SZ];

    logic [SZ*DW-1:0]  a_tr [NC];
    logic [SZ*DW-1:0]  b_tr [NC];
    logic [SZ-1:0]     ra_tr [NC];
    logic [SZ-1:0]     rb_tr [NC];
    logic              ld_tr [NC];
    logic              mu_tr [NC];
    logic              ac_tr [NC];
    logic              bu_tr [NC];
    logic              dn_tr [NC];

    always #5 clk = ~clk;

    tensor_feed_sequencer #(.DATAWIDTH(DW), .SIZE(SZ), .KLEN_W(KW)) dut (
        .clk          (clk),
        .reset        (reset),
        .start        (start),
        .k_len        (k_len),
        .a_fifo_q     (a_fifo_q),
        .a_fifo_empty (a_fifo_empty),
        .b_fifo_q     (b_fifo_q),
        .b_fifo_empty (b_fifo_empty),
        .a_fifo_rdreq (a_fifo_rdreq),
        .b_fifo_rdreq (b_fifo_rdreq),
        .a_in         (a_in),
        .b_in         (b_in),
        .load_en      (load_en),
        .mult_en      (mult_en),
        .acc_en       (acc_en),
        .busy         (busy),
        .done         (done)
`ifdef TENSOR_FEED_PERF_EN
        ,
        .stall_cycles (stall_cycles)
`endif
    );

    // Show-ahead FIFO model: head of lane i is 16*i+k (A) and 100+16*i+k (B) after k pops
    always @(posedge clk) begin
        for (int i = 0; i < SZ; i++) begin
            if (clr_pops) begin
                pop_a[i] <= 0;
                pop_b[i] <= 0;
            end else begin
                if (a_fifo_rdreq[i]) pop_a[i] <= pop_a[i] + 1;
                if (b_fifo_rdreq[i]) pop_b[i] <= pop_b[i] + 1;
            end
        end
    end

    always_comb begin
        a_fifo_q = '0;
        b_fifo_q = '0;
        for (int i = 0; i < SZ; i++) begin
            a_fifo_q[i*DW +: DW] = DW'(16 * i + pop_a[i]);
            b_fifo_q[i*DW +: DW] = DW'(100 + 16 * i + pop_b[i]);
        end
    end

    // Runs one pass from cycle 0 (start) and records outputs per cycle; -1 disables an event
    task automatic run_pass(input int kl, input int stall_c, input int start2_c, input int reset_c);
        clr_pops = 1'b1;
        @(posedge clk); #1;
        clr_pops = 1'b0;
        for (int c = 0; c < NC; c++) begin
            start        = (c == 0) || (c == start2_c);
            k_len        = KW'(kl);
            reset        = (c == reset_c);
            a_fifo_empty = (c == stall_c) ? SZ'(4) : '0;
            #1;
            a_tr[c]  = a_in;
            b_tr[c]  = b_in;
            ra_tr[c] = a_fifo_rdreq;
            rb_tr[c] = b_fifo_rdreq;
            ld_tr[c] = load_en;
            mu_tr[c] = mult_en;
            ac_tr[c] = acc_en;
            bu_tr[c] = busy;
            dn_tr[c] = done;
            @(posedge clk); #1;
        end
        start        = 1'b0;
        reset        = 1'b0;
        a_fifo_empty = '0;
    endtask

    task automatic test_reset;
        logic [2*SZ*DW+2*SZ+5-1:0] obs;
        obs = {a_in, b_in, a_fifo_rdreq, b_fifo_rdreq, load_en, mult_en, acc_en, busy, done};
        total++;
        if (obs !== '0) begin
            bad++;
            $display("FAIL reset_outputs: got %h expected 0", obs);
        end
        reset = 1'b0;
        @(posedge clk); #1;
    endtask

    task automatic test_basic;
        logic [SZ-1:0] exp_rd;
        run_pass(3, -1, -1, -1);
        for (int c = 0; c < NC; c++) begin
            exp_rd = (c >= 2 && c <= 4) ? '1 : '0;
            total += 7;
            if (ld_tr[c] !== (c == 1)) begin
                bad++; $display("FAIL basic_load c=%0d got %b expected %b", c, ld_tr[c], c == 1);
            end
            if (ra_tr[c] !== exp_rd) begin
                bad++; $display("FAIL basic_a_rdreq c=%0d got %b expected %b", c, ra_tr[c], exp_rd);
            end
            if (rb_tr[c] !== exp_rd) begin
                bad++; $display("FAIL basic_b_rdreq c=%0d got %b expected %b", c, rb_tr[c], exp_rd);
            end
            if (mu_tr[c] !== (c >= 3 && c <= 8)) begin
                bad++; $display("FAIL basic_mult c=%0d got %b expected %b", c, mu_tr[c], c >= 3 && c <= 8);
            end
            if (ac_tr[c] !== (c >= 3 && c <= 8)) begin
                bad++; $display("FAIL basic_acc c=%0d got %b expected %b", c, ac_tr[c], c >= 3 && c <= 8);
            end
            if (dn_tr[c] !== (c == 9)) begin
                bad++; $display("FAIL basic_done c=%0d got %b expected %b", c, dn_tr[c], c == 9);
            end
            if (bu_tr[c] !== (c >= 1 && c <= 8)) begin
                bad++; $display("FAIL basic_busy c=%0d got %b expected %b", c, bu_tr[c], c >= 1 && c <= 8);
            end
        end
`ifdef TENSOR_FEED_PERF_EN
        total++;
        if (stall_cycles !== 16'd0) begin
            bad++; $display("FAIL basic_stall_cycles got %0d expected 0", stall_cycles);
        end
`endif
    endtask

    task automatic test_stall;
        logic          exp_rd;
        logic [DW-1:0] got, exp;
        run_pass(3, 3, -1, -1);
        for (int c = 0; c < NC; c++) begin
            exp_rd = (c == 2) || (c == 4) || (c == 5);
            total += 6;
            if (ra_tr[c] !== {SZ{exp_rd}} || rb_tr[c] !== {SZ{exp_rd}}) begin
                bad++; $display("FAIL stall_rdreq c=%0d got %b/%b expected %b", c, ra_tr[c], rb_tr[c], {SZ{exp_rd}});
            end
            if (mu_tr[c] !== (c >= 4 && c <= 9) || ac_tr[c] !== (c >= 4 && c <= 9)) begin
                bad++; $display("FAIL stall_mult_acc c=%0d got %b/%b expected %b", c, mu_tr[c], ac_tr[c], c >= 4 && c <= 9);
            end
            if (dn_tr[c] !== (c == 10)) begin
                bad++; $display("FAIL stall_done c=%0d got %b expected %b", c, dn_tr[c], c == 10);
            end
            if (bu_tr[c] !== (c >= 1 && c <= 9)) begin
                bad++; $display("FAIL stall_busy c=%0d got %b expected %b", c, bu_tr[c], c >= 1 && c <= 9);
            end
            // lane 0 B holds its first value across the stalled cycle
            got = b_tr[c][0 +: DW];
            exp = (c == 3 || c == 4) ? DW'(100) : (c == 5) ? DW'(101) : (c == 6) ? DW'(102) : '0;
            if (got !== exp) begin
                bad++; $display("FAIL stall_b_lane0 c=%0d got %0d expected %0d", c, got, exp);
            end
            got = a_tr[c][3*DW +: DW];
            exp = (c >= 7 && c <= 9) ? DW'(48 + c - 7) : '0;
            if (got !== exp) begin
                bad++; $display("FAIL stall_a_lane3 c=%0d got %0d expected %0d", c, got, exp);
            end
        end
`ifdef TENSOR_FEED_PERF_EN
        total++;
        if (stall_cycles !== 16'd1) begin
            bad++; $display("FAIL stall_cycles got %0d expected 1", stall_cycles);
        end
`endif
    endtask

    task automatic test_zero_len;
        run_pass(0, -1, -1, -1);
        for (int c = 0; c < NC; c++) begin
            total += 5;
            if (ld_tr[c] !== (c == 1)) begin
                bad++; $display("FAIL zero_load c=%0d got %b expected %b", c, ld_tr[c], c == 1);
            end
            if (dn_tr[c] !== (c == 2)) begin
                bad++; $display("FAIL zero_done c=%0d got %b expected %b", c, dn_tr[c], c == 2);
            end
            if (bu_tr[c] !== (c == 1)) begin
                bad++; $display("FAIL zero_busy c=%0d got %b expected %b", c, bu_tr[c], c == 1);
            end
            if (ra_tr[c] !== '0 || rb_tr[c] !== '0) begin
                bad++; $display("FAIL zero_rdreq c=%0d got %b/%b expected 0", c, ra_tr[c], rb_tr[c]);
            end
            if (mu_tr[c] !== 1'b0 || ac_tr[c] !== 1'b0) begin
                bad++; $display("FAIL zero_mult_acc c=%0d got %b/%b expected 0", c, mu_tr[c], ac_tr[c]);
            end
        end
    endtask

    task automatic test_ignored_start;
        int ndone;
        run_pass(3, -1, 4, -1);
        ndone = 0;
        for (int c = 0; c < NC; c++) begin
            if (dn_tr[c] === 1'b1) ndone++;
        end
        total += 3;
        if (ndone != 1) begin
            bad++; $display("FAIL ignored_done_count got %0d expected 1", ndone);
        end
        if (dn_tr[9] !== 1'b1) begin
            bad++; $display("FAIL ignored_done_c9 got %b expected 1", dn_tr[9]);
        end
        if (bu_tr[10] !== 1'b0 || bu_tr[8] !== 1'b1) begin
            bad++; $display("FAIL ignored_busy got c8=%b c10=%b expected 1/0", bu_tr[8], bu_tr[10]);
        end
    endtask

    task automatic test_reset_mid;
        run_pass(3, -1, -1, 5);
        total += 4;
        if (bu_tr[5] !== 1'b1 || mu_tr[5] !== 1'b1) begin
            bad++; $display("FAIL rmid_pre c5 got busy=%b mult=%b expected 1/1", bu_tr[5], mu_tr[5]);
        end
        if (a_tr[6] !== '0 || b_tr[6] !== '0) begin
            bad++; $display("FAIL rmid_data c6 got %h/%h expected 0", a_tr[6], b_tr[6]);
        end
        if (ra_tr[6] !== '0 || rb_tr[6] !== '0 || ld_tr[6] !== 1'b0) begin
            bad++; $display("FAIL rmid_ctl c6 got rd=%b/%b load=%b expected 0", ra_tr[6], rb_tr[6], ld_tr[6]);
        end
        if (mu_tr[6] !== 1'b0 || ac_tr[6] !== 1'b0 || bu_tr[6] !== 1'b0 || dn_tr[6] !== 1'b0) begin
            bad++; $display("FAIL rmid_status c6 got m=%b a=%b b=%b d=%b expected 0", mu_tr[6], ac_tr[6], bu_tr[6], dn_tr[6]);
        end
        test_basic();
    endtask

    task automatic test_lane_data;
        logic [DW-1:0] got_a, got_b, exp_a, exp_b;
        int k;
        run_pass(3, -1, -1, -1);
        for (int c = 0; c < NC; c++) begin
            for (int i = 0; i < SZ; i++) begin
                k = c - 3 - i;
                exp_a = (k >= 0 && k <= 2) ? DW'(16 * i + k) : '0;
                exp_b = (k >= 0 && k <= 2) ? DW'(100 + 16 * i + k) : '0;
                got_a = a_tr[c][i*DW +: DW];
                got_b = b_tr[c][i*DW +: DW];
                total += 2;
                if (got_a !== exp_a) begin
                    bad++; $display("FAIL lane_a c=%0d lane=%0d got %0d expected %0d", c, i, got_a, exp_a);
                end
                if (got_b !== exp_b) begin
                    bad++; $display("FAIL lane_b c=%0d lane=%0d got %0d expected %0d", c, i, got_b, exp_b);
                end
            end
        end
    endtask

    initial begin
        reset        = 1'b1;
        start        = 1'b0;
        clr_pops     = 1'b1;
        k_len        = '0;
        a_fifo_empty = '0;
        b_fifo_empty = '0;
        repeat (2) @(posedge clk);
        #1;
        test_reset();
        test_basic();
        test_stall();
        test_zero_len();
        test_ignored_start();
        test_reset_mid();
        test_lane_data();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
